// File: rtl/point_encode_tx.sv
// point_encode_tx: RFC 8032 point compression of an affine (x, y) result, streamed as 32 bytes LSB-first.
// Latency: out_valid rises 2 cycles after the accept edge; 34 cycles accept-to-accept with out_ready high.
// Backpressure: out_ready low holds the current byte; in_ready stays low until the last byte is taken.
// Optional self-check against an expected encoding is compiled in with `define CHECK_EN.

`ifndef P25519
`define P25519 ({255{1'b1}} - 255'd18)
`endif

module point_encode_tx #(
    parameter int             N = 255,
    parameter logic [N-1:0]   P = `P25519
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      in_x,
    input  logic [N-1:0]      in_y,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
`ifdef CHECK_EN
    ,
    input  logic [N:0]        exp_enc,
    output logic [7:0]        match_count,
    output logic              mismatch
`endif
);

    // Encoding is y with the x sign bit on top: N+1 bits, a whole number of bytes.
    localparam int ENC_W  = N + 1;
    localparam int NBYTES = ENC_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t             state;
    logic [N-1:0]       x_q;
    logic [N-1:0]       y_q;
    logic [ENC_W-1:0]   enc_q;
    logic [IDX_W-1:0]   idx;

    logic               y_ge_p;
    logic               x_ge_p;
    logic [N-1:0]       y_red;
    logic               x_par;
    logic [ENC_W-1:0]   enc_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               xfer;

    // Single conditional subtract brings each coordinate into [0, P); only the parity of x survives.
    always_comb begin
        y_ge_p  = (y_q >= P);
        x_ge_p  = (x_q >= P);
        y_red   = y_ge_p ? (y_q - P) : y_q;
        // Subtracting P never borrows into bit 0, so reduced parity is x[0] flipped by P[0] when reducing.
        x_par   = x_q[0] ^ (x_ge_p & P[0]);
        enc_nxt = {x_par, y_red};
        idx_nxt = idx + IDX_W'(1);
        xfer    = out_valid & out_ready;
    end

    // Accept, reduce, then stream the captured encoding one byte per handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            enc_q     <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        x_q      <= in_x;
                        y_q      <= in_y;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_REDUCE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_REDUCE: begin
                    enc_q     <= enc_nxt;
                    idx       <= '0;
                    out_data  <= enc_nxt[7:0];
                    out_last  <= (LAST_IDX == '0);
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            // Reopening in_ready here keeps accept-to-accept at the minimum.
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            idx       <= '0;
                            in_ready  <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= enc_q[{idx_nxt, 3'b000} +: 8];
                            out_last <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHECK_EN
    // Compare each fresh encoding with the expected value while it is being formed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            match_count <= 8'd0;
            mismatch    <= 1'b0;
        end else if (state == ST_REDUCE) begin
            if (enc_nxt == exp_enc) begin
                if (match_count != 8'hFF) begin
                    match_count <= match_count + 8'd1;
                end
            end else begin
                mismatch <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_point_encode_tx.sv
// tb_point_encode_tx: directed and random encodings checked byte-by-byte against a modular-arithmetic model.
// Latency: checks out_valid two cycles after accept and in_ready back right after the last byte.
// Backpressure: drives stalls and random out_ready; holds in_valid through SEND to probe re-accept.

module tb_point_encode_tx;

    localparam logic [255:0] PM = (256'd1 << 255) - 256'd19;
    localparam logic [254:0] BX = 255'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
    localparam logic [254:0] BY = 255'h6666666666666666666666666666666666666666666666666666666666666658;

    logic          clk = 1'b0;
    logic          rstn;
    logic [254:0]  in_x;
    logic [254:0]  in_y;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
`ifdef CHECK_EN
    logic [255:0]  exp_enc;
    logic [7:0]    match_count;
    logic          mismatch;
`endif

    int errors = 0;
    int checks = 0;

    point_encode_tx dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
`ifdef CHECK_EN
        ,
        .exp_enc    (exp_enc),
        .match_count(match_count),
        .mismatch   (mismatch)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: compressed point = (y mod P) with (x mod P) parity in bit 255.
    function automatic logic [255:0] model(input logic [254:0] x, input logic [254:0] y);
        logic [255:0] xm;
        logic [255:0] ym;
        xm = {1'b0, x} % PM;
        ym = {1'b0, y} % PM;
        return ym | ((xm & 256'd1) << 255);
    endfunction

    function automatic logic [254:0] rnd255();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[255:1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; checks latency, every presented byte, out_last and the handshakes.
    task automatic run_tx(input string tag, input logic [254:0] x, input logic [254:0] y,
                          input int stall_at, input int stall_len, input bit rand_rdy,
                          input bit hold_valid, output logic [255:0] got);
        logic [255:0] exp;
        int cyc;
        int n;
        int stalled;
        int bad;
        exp  = model(x, y);
        got  = '0;
        in_x = x;
        in_y = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, " in_ready_before_accept"}, in_ready, 1);
        tick();
        if (!hold_valid) in_valid = 1'b0;
        chk({tag, " reduce_state"}, {busy, in_ready, out_valid}, 3'b100);
        tick();
        chk({tag, " out_valid_latency"}, out_valid, 1);
        n = 0; stalled = 0; bad = 0; cyc = 0;
        while (n < 32 && cyc < 1000) begin
            if (n == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else if (rand_rdy) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
                out_data !== exp[8*n +: 8] || out_last !== (n == 31))
                bad++;
            if (out_valid === 1'b1 && out_ready) begin
                got[8*n +: 8] = out_data;
                n++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, " byte_stream"}, bad, 0);
        chk({tag, " transfer_count"}, n, 32);
        chk({tag, " encoding"}, got, exp);
        chk({tag, " after_last"}, {out_valid, out_last, busy, in_ready}, 4'b0001);
    endtask

    initial begin
        logic [255:0] got;
        logic [254:0] rx;
        logic [254:0] ry;
        rstn = 1'b0;
        in_x = '0;
        in_y = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef CHECK_EN
        exp_enc = '0;
`endif
        // Reset state
        tick(); tick(); tick();
        chk("reset_outputs", {in_ready, out_valid, out_last, busy, out_data}, 12'h000);
        rstn = 1'b1;
        tick();
        chk("in_ready_after_release", in_ready, 1);

`ifdef CHECK_EN
        chk("chk_reset_state", {match_count, mismatch}, 9'd0);
        exp_enc = model(BX, BY);
        run_tx("chk_base1", BX, BY, -1, 0, 1'b0, 1'b0, got);
        run_tx("chk_base2", BX, BY, -1, 0, 1'b0, 1'b0, got);
        chk("chk_two_matches", {match_count, mismatch}, {8'd2, 1'b0});
        run_tx("chk_y1", 255'd0, 255'd1, -1, 0, 1'b0, 1'b0, got);
        chk("chk_mismatch_sticky", {match_count, mismatch}, {8'd2, 1'b1});
`endif

        // Directed vectors with independently known encodings
        run_tx("t1_x0_y1", 255'd0, 255'd1, -1, 0, 1'b0, 1'b0, got);
        chk("t1_const", got, 256'd1);
        run_tx("t2_base", BX, BY, -1, 0, 1'b0, 1'b0, got);
        chk("t2_const", got, 256'h6666666666666666666666666666666666666666666666666666666666666658);
        run_tx("t3_reduce_y", 255'd1, PM[254:0] + 255'd5, -1, 0, 1'b0, 1'b0, got);
        chk("t3_const", got, {8'h80, 240'd0, 8'h05});
        run_tx("t3b_reduce_x", PM[254:0] + 255'd2, PM[254:0], -1, 0, 1'b0, 1'b0, got);
        chk("t3b_const", got, 256'd0);
        run_tx("t3c_below_p", PM[254:0] - 255'd1, PM[254:0] - 255'd1, -1, 0, 1'b0, 1'b0, got);

        // Stall at byte 10 with in_valid held high through SEND
        run_tx("t4_stall", BX, BY, 10, 3, 1'b0, 1'b1, got);

        // Reset while byte 17 is on the port
        in_x = BX;
        in_y = BY;
        in_valid = 1'b1;
        chk("t5_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("t5_byte17", {out_valid, out_data}, {1'b1, 8'h66});
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        out_ready = 1'b0;
        chk("t5_after_reset", {out_valid, busy, in_ready, out_last, out_data}, 12'h000);
        tick();
        chk("t5_ready_back", in_ready, 1);
        run_tx("t5_restart", 255'd0, 255'd1, -1, 0, 1'b0, 1'b0, got);

        // Random coordinates, including values just above P, with random backpressure
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 2))
                0: begin rx = rnd255(); ry = rnd255(); end
                1: begin
                    rx = PM[254:0] + 255'($urandom_range(0, 18));
                    ry = PM[254:0] + 255'($urandom_range(0, 18));
                end
                default: begin rx = 255'($urandom()); ry = PM[254:0] - 255'($urandom_range(0, 40)); end
            endcase
            run_tx($sformatf("rnd%0d", k), rx, ry, -1, 0, 1'b1, k[0], got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
